fwd_mux_n: RTL
==============

# fwd_mux_n

Parametrised operand-forwarding selector for the pipelined datapath. It generalises the fixed 2/3/4/5-input data muxes into an N-slot result-tracking buffer. The buffer records the destination tag, readiness and data of every in-flight instruction. For each of NRD read ports it picks, combinationally, either the register-file value or the youngest matching in-flight result, and raises a hazard when the youngest match is not yet ready. It sits between the register file read stage and the ALU operand inputs.

## Interface
- WIDTH, 32, data width
- TAGW, 5, register tag width
- DEPTH, 3, in-flight slots (1..7); slot 0 is the youngest
- NRD, 2, number of read ports
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all slots
- hold  in  1  freeze: no shift, no insert; updates still apply
- bubble  in  1  insert an empty entry into slot 0 instead of in_*
- in_valid  in  1  new instruction writes a register
- in_tag  in  TAGW  its destination tag
- in_ready  in  1  result already known at entry
- in_data  in  WIDTH  that result (ignored if !in_ready)
- upd_en  in  1  a result becomes available
- upd_slot  in  3  slot index (pre-shift) receiving the result
- upd_data  in  WIDTH  result value
- rd_tag  in  NRD*TAGW  read tags, port i at [i*TAGW +: TAGW]
- rf_data  in  NRD*WIDTH  register-file values per port
- rd_data  out  NRD*WIDTH  selected operand per port
- rd_sel  out  NRD*3  0 = register file, k = slot k-1
- hazard  out  NRD  youngest match is not ready; consumer must stall

## Operation
- Slot state: valid, tag, ready, data.
- Advance: on each edge with !hold, slot k+1 takes slot k. The entry in slot DEPTH-1 retires and is dropped.
- Slot 0 fill on advance: if bubble=1 or in_valid=0 or in_tag=0, slot 0 becomes invalid. Otherwise it becomes {1, in_tag, in_ready, in_ready ? in_data : 0}.
- hold=1: all slots keep position. bubble and in_* are ignored.
- Update: upd_en writes data and sets ready on the entry that was in upd_slot before the edge. The write follows that entry.
  - Advancing: the write lands in upd_slot+1.
  - Advancing with upd_slot=DEPTH-1: the update is discarded.
  - Holding: the write lands in upd_slot.
- Update to an invalid slot, or with upd_slot ≥ DEPTH, is ignored.
- Read port i:
  - rd_tag=0, or no valid slot with a matching tag: rd_data=rf_data, rd_sel=0, hazard=0.
  - Otherwise the lowest-index matching slot k wins.
  - If slot k is ready: rd_data=slot data, rd_sel=k+1, hazard=0.
  - If slot k is not ready: rd_data=rf_data, rd_sel=k+1, hazard=1. Older ready matches are never used past a non-ready younger match.
- The block does not stall itself. The control unit drives hold/bubble from hazard.

## Timing
- Read path is purely combinational on registered slot state. An update or insert is visible to reads the cycle after its edge. There is no same-cycle bypass of upd_data or in_data.
- reset: all slots invalid, tag 0, ready 0, data 0. Resulting outputs: rd_data=rf_data, rd_sel=0, hazard=0.
- reset has priority over hold, bubble, insert and update. Asserting reset mid-stream discards all in-flight entries in one cycle.
- hold and bubble both high: hold wins.
- Two slots with the same tag are legal. The younger slot always shadows the older one.
- Latency from insert to retirement is DEPTH advancing edges.

## Test plan
- Reset: in_valid=1, tag 8 inserted, then reset for 1 cycle. Required: all rd_sel=0, hazard=0, and rd_data equals rf_data for any tag.
- Basic forward: insert tag 4, ready, 0xAAAA0001, then advance. Required: rd_tag=4 gives rd_data=0xAAAA0001, rd_sel=1. On the next advance, rd_sel=2. After DEPTH=3 advances, rd_sel=0 and rd_data=rf_data.
- Load-use hazard and bubble:
  - Insert tag 9, not ready. Next cycle rd_tag=9 gives hazard=1. Drive bubble=1 with upd_en, upd_slot=0, data 0x12345678.
  - Required next cycle: slot 1 holds tag 9 ready, rd_data=0x12345678, rd_sel=2, hazard=0, and slot 0 is invalid.
- Shadowing:
  - Insert tag 3 ready 0x11, then tag 3 not ready. Required: hazard=1 and rd_sel=1; 0x11 is never output.
  - Then update slot 0 with 0x22 without advancing (hold=1). Required next cycle: rd_data=0x22, rd_sel=1.
- Zero tag and hold: insert tag 0 ready 0xFF. Required: rd_tag=0 returns rf_data. Drive hold=1 for 3 cycles with in_valid=1, tag 5. Required: no slot changes and tag 5 never matches.
- Dual port / edge: NRD=2 with port 0 tag 4 and port 1 tag 7, both in flight. Required: independent rd_sel/rd_data per port. An update with upd_slot=2 (=DEPTH-1) during an advance is discarded, so nothing matches afterwards.

Source files
------------

// File: rtl/fwd_mux_n.sv
// fwd_mux_n: in-flight result tracking buffer with per-port operand forwarding.
// Slot 0 holds the youngest instruction; each advancing edge shifts every entry
// one slot older and the oldest entry retires. Reads are combinational on the
// registered slot state, so inserts and updates show up the cycle after their edge.
module fwd_mux_n #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5,
  parameter int DEPTH = 3,
  parameter int NRD   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  bubble,
  input  logic                  in_valid,
  input  logic [TAGW-1:0]       in_tag,
  input  logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  upd_en,
  input  logic [2:0]            upd_slot,
  input  logic [WIDTH-1:0]      upd_data,
  input  logic [NRD*TAGW-1:0]   rd_tag,
  input  logic [NRD*WIDTH-1:0]  rf_data,
  output logic [NRD*WIDTH-1:0]  rd_data,
  output logic [NRD*3-1:0]      rd_sel,
  output logic [NRD-1:0]        hazard
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [TAGW-1:0]  tag_q  [DEPTH];
  logic [TAGW-1:0]  tag_d  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // A zero destination tag never writes a register, so it is never tracked.
  logic ins_ok;
  assign ins_ok = !bubble && in_valid && (in_tag != '0);

  // Next slot state: optional shift/insert, then the result update that follows its entry.
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    for (int k = 0; k < DEPTH; k++) begin
      tag_d[k]  = tag_q[k];
      data_d[k] = data_q[k];
    end

    if (!hold) begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        ready_d[k] = ready_q[k-1];
        tag_d[k]   = tag_q[k-1];
        data_d[k]  = data_q[k-1];
      end
      valid_d[0] = ins_ok;
      ready_d[0] = ins_ok && in_ready;
      tag_d[0]   = ins_ok ? in_tag : '0;
      data_d[0]  = (ins_ok && in_ready) ? in_data : '0;

      // The entry moved one slot older; an update aimed at the retiring slot is lost.
      for (int k = 1; k < DEPTH; k++) begin
        if (upd_en && (upd_slot == 3'(k-1)) && valid_q[k-1]) begin
          ready_d[k] = 1'b1;
          data_d[k]  = upd_data;
        end
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (upd_en && (upd_slot == 3'(k)) && valid_q[k]) begin
          ready_d[k] = 1'b1;
          data_d[k]  = upd_data;
        end
      end
    end
  end

  // Slot registers with synchronous reset taking priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      ready_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k]  <= tag_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [TAGW-1:0]  port_tag;
    logic [WIDTH-1:0] port_rf;
    logic             hit;
    logic             hit_ready;
    logic [2:0]       hit_sel;
    logic [WIDTH-1:0] hit_data;

    assign port_tag = rd_tag[gi*TAGW +: TAGW];
    assign port_rf  = rf_data[gi*WIDTH +: WIDTH];

    // Scan oldest to youngest so the youngest matching slot is the one that sticks.
    always_comb begin
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_sel   = 3'd0;
      hit_data  = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (valid_q[k] && (tag_q[k] == port_tag) && (port_tag != '0)) begin
          hit       = 1'b1;
          hit_ready = ready_q[k];
          hit_sel   = 3'(k + 1);
          hit_data  = data_q[k];
        end
      end
    end

    assign rd_sel[gi*3 +: 3]        = hit ? hit_sel : 3'd0;
    assign rd_data[gi*WIDTH +: WIDTH] = (hit && hit_ready) ? hit_data : port_rf;
    assign hazard[gi]               = hit && !hit_ready;
  end

endmodule
